pkt_rx_dma: RTL and testbench
=============================

# pkt_rx_dma

Ingress packet writer on the switch's SRAM port. It accepts a byte stream with start/end-of-packet markers and packs the bytes little-endian into 32-bit words. Each word is written into a ring buffer region of the shared SRAM using the same ce/we/addr/sel/data bus the switch core uses. For each completed packet it posts a descriptor (start address, byte length) to the switch core. SRAM space is returned by the core through a release port.

## Interface
Parameters:
- BUF_BASE, 32'h0000_1000, byte address of ring word 0; word aligned.
- BUF_WORDS, 256, ring size in 32-bit words; power of two, 4..4096.
- DESC_DEPTH, 4, descriptor FIFO entries; power of two.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte present on input.
- in_ready  out  1  block accepts byte this cycle.
- in_data  in  8  packet byte.
- in_sop  in  1  first byte of packet.
- in_eop  in  1  last byte of packet; sop and eop may both be set (1-byte packet).
- sram_ce_o  out  1  SRAM access strobe.
- sram_we_o  out  1  write enable; always equal to sram_ce_o.
- sram_addr_o  out  32  byte address; bits [1:0] = 0.
- sram_sel_o  out  4  byte-lane enables; bit k = byte lane k.
- sram_data_o  out  32  write data; disabled lanes driven 0.
- desc_valid  out  1  descriptor FIFO not empty.
- desc_ready  in  1  consumer pops the head descriptor.
- desc_addr  out  32  byte address of the packet's first word.
- desc_len  out  16  packet length in bytes.
- rel_valid  in  1  one-cycle pulse; consumer frees ring words.
- rel_words  in  13  number of words freed, in ring order.
- drop_cnt  out  16  count of dropped packets; saturates at 16'hFFFF.

## Operation
- A byte is transferred when in_valid & in_ready.
- State machine IDLE / RECV / DROP / COMMIT.
- in_ready is 1 in IDLE, RECV and DROP, and 0 in COMMIT.
- IDLE:
  - A transferred byte with sop: record start = wr_ptr, clear the packer and byte count, load the byte into lane 0, go to RECV. If eop is also set, the word completes immediately.
  - A transferred byte without sop is discarded silently; not counted.
- RECV:
  - Each byte goes into lane (len mod 4); len increments.
  - A word completes on the 4th lane or on eop. A completed word is written on the next cycle at wr_ptr, with sel = the filled lanes. wr_ptr then advances one word and wraps from BUF_BASE+4*(BUF_WORDS-1) to BUF_BASE. occupied then increments.
  - eop → COMMIT.
- Overflow: if a word completes while occupied == BUF_WORDS:
  - No write is issued.
  - wr_ptr rewinds to start, and occupied is reduced by the words this packet already wrote.
  - drop_cnt increments.
  - Next state is IDLE if the byte had eop, otherwise DROP.
- sop seen in RECV:
  - The byte is not accepted; in_ready is 0 that cycle.
  - The current packet is aborted as for overflow, then the block goes to IDLE.
  - The same byte is accepted on the next cycle as a new packet.
- DROP: consumes bytes until eop, then goes to IDLE; no SRAM writes.
- COMMIT:
  - If the FIFO is not full, push {start, len} and go to IDLE.
  - If the FIFO is full, stay in COMMIT. The push happens in the first cycle in which there is space; a pop in the same cycle frees space for that push.
- occupied: +1 per word written, −rel_words on rel_valid; both apply in the same cycle if simultaneous. rel_words > occupied is a consumer error; occupied clamps to 0.
- Descriptor FIFO: first-word-fall-through. desc_addr/desc_len are the head entry, valid while desc_valid.

## Timing
- Reset values:
  - sram_ce_o=0, sram_we_o=0, sram_addr_o=0, sram_sel_o=0, sram_data_o=0.
  - desc_valid=0, desc_addr=0, desc_len=0, drop_cnt=0.
  - State IDLE, so in_ready=1.
  - wr_ptr=BUF_BASE, occupied=0, FIFO empty.
- SRAM outputs are registered. ce/we are high for exactly one cycle per word, and at most one write is issued per cycle.
- Latency:
  - Byte completing a word accepted at cycle t → write strobe at t+1.
  - eop accepted at t → COMMIT at t+1, desc_valid visible at t+2 if the FIFO had space.
- Asynchronous reset mid-packet discards the packet, all FIFO contents and the ring accounting. SRAM contents are untouched.

## Test plan
- Reset and idle → all outputs at their reset values; in_ready=1; no sram_ce_o with in_valid=0.
- 6-byte packet 01..06, defaults:
  - write 0x1000 / 0x04030201 / sel 1111;
  - then write 0x1004 / 0x00000605 / sel 0011;
  - descriptor {0x1000, 6}.
- Wrap, BUF_WORDS=4: 8-byte packet, then rel_valid with rel_words=2, then 12-byte packet 11..1C:
  - writes at 0x1008, 0x100C, 0x1000;
  - descriptor {0x1008, 12}; drop_cnt=0.
- Overflow, BUF_WORDS=4, no release: 20-byte packet → 4 writes, no 5th write, no descriptor, drop_cnt=1. A following 1-byte packet is written at 0x1000.
- Descriptor back-pressure, DESC_DEPTH=4, desc_ready=0: five 1-byte packets → 4 descriptors held; in_ready=0 stuck in COMMIT. Raise desc_ready → fifth descriptor {0x1010, 1} pops in order.
- sop after 3 bytes of a packet → in_ready=0 for one cycle, drop_cnt=1. The new packet starts at the aborted start address, and the aborted bytes produce no descriptor.

Source files
------------

// File: rtl/pkt_rx_dma.sv
// pkt_rx_dma -- ingress packet writer on the switch SRAM port.
//
// Packs an 8-bit sop/eop byte stream little-endian into 32-bit words and writes
// them into a ring region of the shared SRAM. Each completed packet posts a
// {start address, byte length} descriptor into a first-word-fall-through FIFO.
// Ring space comes back from the switch core through the release port.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   in_valid/in_ready/in_data      byte stream handshake and data
//   in_sop/in_eop                  packet delimiters (both set = 1-byte packet)
//   sram_ce_o/we_o/addr_o/sel_o/data_o  registered SRAM write port
//   desc_valid/desc_ready/desc_addr/desc_len  descriptor FIFO head
//   rel_valid/rel_words            ring words returned by the consumer
//   drop_cnt                       saturating count of dropped packets
module pkt_rx_dma #(
  parameter logic [31:0] BUF_BASE   = 32'h0000_1000,
  parameter int unsigned BUF_WORDS  = 256,
  parameter int unsigned DESC_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        sram_ce_o,
  output logic        sram_we_o,
  output logic [31:0] sram_addr_o,
  output logic [3:0]  sram_sel_o,
  output logic [31:0] sram_data_o,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic [31:0] desc_addr,
  output logic [15:0] desc_len,
  input  logic        rel_valid,
  input  logic [12:0] rel_words,
  output logic [15:0] drop_cnt
);

  localparam int unsigned AW = $clog2(BUF_WORDS);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned DW = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
  localparam int unsigned CW = $clog2(DESC_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP, S_COMMIT} state_t;

  state_t        r_state, w_state_nxt;

  logic [AW-1:0] r_wr_idx, r_start;
  logic [OW-1:0] r_occ, r_pkt_words, w_occ_nxt;
  logic [15:0]   r_len;
  logic [31:0]   r_pack, w_word;
  logic [3:0]    r_psel, w_sel;
  logic [1:0]    w_lane;
  logic          w_accept, w_take, w_complete, w_full, w_ovf, w_wr;
  logic          w_abort, w_drop, w_rewind;
  logic [14:0]   w_add, w_sub;
  logic [31:0]   w_wr_addr, w_start_addr;

  logic          r_sram_ce;
  logic [31:0]   r_sram_addr, r_sram_data;
  logic [3:0]    r_sram_sel;
  logic [15:0]   r_drop_cnt;

  logic [31:0]   r_fa [DESC_DEPTH];
  logic [15:0]   r_fl [DESC_DEPTH];
  logic [DW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop, w_ffull;

  function automatic logic [DW-1:0] fifo_inc(input logic [DW-1:0] p);
    return (p == DW'(DESC_DEPTH - 1)) ? '0 : p + DW'(1);
  endfunction

  // A sop arriving mid-packet is held off for one cycle while the packet
  // in progress is aborted; it is then taken as a fresh packet from IDLE.
  assign w_abort  = (r_state == S_RECV) & in_valid & in_sop;
  assign in_ready = (r_state != S_COMMIT) & ~w_abort;
  assign w_accept = in_valid & in_ready;
  assign w_take   = w_accept & (((r_state == S_IDLE) & in_sop) | (r_state == S_RECV));
  assign w_lane   = (r_state == S_IDLE) ? 2'd0 : r_len[1:0];

  always_comb begin
    w_word = (r_state == S_IDLE) ? '0 : r_pack;
    w_sel  = (r_state == S_IDLE) ? '0 : r_psel;
    w_word[{w_lane, 3'b000} +: 8] = in_data;
    w_sel[w_lane] = 1'b1;
  end

  assign w_complete = w_take & ((w_lane == 2'd3) | in_eop);
  assign w_full     = (r_occ == OW'(BUF_WORDS));
  assign w_ovf      = w_complete & w_full;
  assign w_wr       = w_complete & ~w_full;
  assign w_drop     = w_ovf | w_abort;
  // Only a packet already in RECV can have ring words to hand back.
  assign w_rewind   = w_drop & (r_state == S_RECV);

  // Write and release may land together; an over-release clamps at empty.
  assign w_add     = 15'(r_occ) + 15'(w_wr);
  assign w_sub     = (rel_valid ? 15'(rel_words) : '0) + (w_rewind ? 15'(r_pkt_words) : '0);
  assign w_occ_nxt = (w_sub > w_add) ? '0 : OW'(w_add - w_sub);

  assign w_wr_addr    = BUF_BASE + {{(30-AW){1'b0}}, r_wr_idx, 2'b00};
  assign w_start_addr = BUF_BASE + {{(30-AW){1'b0}}, r_start, 2'b00};

  assign w_ffull = (r_cnt == CW'(DESC_DEPTH));
  assign w_pop   = (r_cnt != '0) & desc_ready;
  // A same-cycle pop makes room for the push even when the FIFO is full.
  assign w_push  = (r_state == S_COMMIT) & (~w_ffull | w_pop);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          if (in_eop) w_state_nxt = w_ovf ? S_IDLE : S_COMMIT;
          else        w_state_nxt = S_RECV;
        end
      end
      S_RECV: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_take) begin
          if (w_ovf)       w_state_nxt = in_eop ? S_IDLE : S_DROP;
          else if (in_eop) w_state_nxt = S_COMMIT;
        end
      end
      S_DROP: begin
        if (w_accept & in_eop) w_state_nxt = S_IDLE;
      end
      S_COMMIT: begin
        if (w_push) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_idx    <= '0;
      r_start     <= '0;
      r_occ       <= '0;
      r_pkt_words <= '0;
      r_len       <= '0;
      r_pack      <= '0;
      r_psel      <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_take) begin
        if (r_state == S_IDLE) begin
          r_start <= r_wr_idx;
          r_len   <= 16'd1;
        end else begin
          r_len   <= r_len + 16'd1;
        end
        if (w_complete) begin
          r_pack <= '0;
          r_psel <= '0;
        end else begin
          r_pack <= w_word;
          r_psel <= w_sel;
        end
      end
      if (w_take && (r_state == S_IDLE)) r_pkt_words <= OW'(w_wr);
      else if (w_wr)                     r_pkt_words <= r_pkt_words + OW'(1);
      if (w_wr)          r_wr_idx <= r_wr_idx + AW'(1);
      else if (w_rewind) r_wr_idx <= r_start;
      r_occ <= w_occ_nxt;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sram_ce   <= 1'b0;
      r_sram_addr <= '0;
      r_sram_sel  <= '0;
      r_sram_data <= '0;
    end else begin
      r_sram_ce   <= w_wr;
      r_sram_addr <= w_wr ? w_wr_addr : '0;
      r_sram_sel  <= w_wr ? w_sel : '0;
      r_sram_data <= w_wr ? w_word : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DESC_DEPTH; i++) begin
        r_fa[i] <= '0;
        r_fl[i] <= '0;
      end
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fa[r_wr] <= w_start_addr;
        r_fl[r_wr] <= r_len;
        r_wr       <= fifo_inc(r_wr);
      end
      if (w_pop) r_rd <= fifo_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign sram_ce_o   = r_sram_ce;
  assign sram_we_o   = r_sram_ce;
  assign sram_addr_o = r_sram_addr;
  assign sram_sel_o  = r_sram_sel;
  assign sram_data_o = r_sram_data;
  assign desc_valid  = (r_cnt != '0);
  assign desc_addr   = desc_valid ? r_fa[r_rd] : '0;
  assign desc_len    = desc_valid ? r_fl[r_rd] : '0;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_pkt_rx_dma.sv
// Bench for pkt_rx_dma: instance 0 uses default parameters, instance 1 a
// 4-word ring. A packet-level model predicts SRAM writes and descriptors.
module tb_pkt_rx_dma;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid [2];
  logic        in_ready [2];
  logic [7:0]  in_data  [2];
  logic        in_sop   [2];
  logic        in_eop   [2];
  logic        sram_ce_o   [2];
  logic        sram_we_o   [2];
  logic [31:0] sram_addr_o [2];
  logic [3:0]  sram_sel_o  [2];
  logic [31:0] sram_data_o [2];
  logic        desc_valid [2];
  logic        desc_ready [2];
  logic [31:0] desc_addr  [2];
  logic [15:0] desc_len   [2];
  logic        rel_valid  [2];
  logic [12:0] rel_words  [2];
  logic [15:0] drop_cnt   [2];

  pkt_rx_dma #(.BUF_BASE(BASE)) u_big (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_sop(in_sop[0]), .in_eop(in_eop[0]),
    .sram_ce_o(sram_ce_o[0]), .sram_we_o(sram_we_o[0]), .sram_addr_o(sram_addr_o[0]),
    .sram_sel_o(sram_sel_o[0]), .sram_data_o(sram_data_o[0]),
    .desc_valid(desc_valid[0]), .desc_ready(desc_ready[0]),
    .desc_addr(desc_addr[0]), .desc_len(desc_len[0]),
    .rel_valid(rel_valid[0]), .rel_words(rel_words[0]), .drop_cnt(drop_cnt[0])
  );

  pkt_rx_dma #(.BUF_BASE(BASE), .BUF_WORDS(4), .DESC_DEPTH(4)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_sop(in_sop[1]), .in_eop(in_eop[1]),
    .sram_ce_o(sram_ce_o[1]), .sram_we_o(sram_we_o[1]), .sram_addr_o(sram_addr_o[1]),
    .sram_sel_o(sram_sel_o[1]), .sram_data_o(sram_data_o[1]),
    .desc_valid(desc_valid[1]), .desc_ready(desc_ready[1]),
    .desc_addr(desc_addr[1]), .desc_len(desc_len[1]),
    .rel_valid(rel_valid[1]), .rel_words(rel_words[1]), .drop_cnt(drop_cnt[1])
  );

  typedef struct { int inst; logic [31:0] addr; logic [3:0] sel; logic [31:0] data; } wr_t;
  typedef struct { int inst; logic [31:0] addr; logic [15:0] len; } desc_t;

  wr_t   exp_wr[$],   act_wr[$];
  desc_t exp_desc[$], act_desc[$];
  wr_t   cw_e, cw_a;
  desc_t cd_e, cd_a;

  logic [7:0] pkt_q[$];
  int m_wr[2], m_occ[2], m_drop[2], m_n[2];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packet-level model: words fill little-endian, a word completes every
  // 4 bytes or at eop, a full ring drops the packet and rewinds its words.
  task automatic model_pkt(input int k, input bit aborted);
    int start = m_wr[k];
    int written = 0;
    bit dropped = 0;
    logic [31:0] w = '0;
    logic [3:0]  s = '0;
    wr_t   e;
    desc_t d;
    for (int i = 0; i < pkt_q.size(); i++) begin
      w[8*(i%4) +: 8] = pkt_q[i];
      s[i%4] = 1'b1;
      if ((i % 4 == 3) || (!aborted && i == pkt_q.size() - 1)) begin
        if (m_occ[k] == m_n[k]) begin
          dropped = 1;
          break;
        end
        e.inst = k; e.addr = BASE + 32'(4 * m_wr[k]); e.sel = s; e.data = w;
        exp_wr.push_back(e);
        m_wr[k] = (m_wr[k] + 1) % m_n[k];
        m_occ[k]++;
        written++;
        w = '0;
        s = '0;
      end
    end
    if (dropped || aborted) begin
      m_wr[k] = start;
      m_occ[k] -= written;
      m_drop[k]++;
    end else begin
      d.inst = k; d.addr = BASE + 32'(4 * start); d.len = 16'(pkt_q.size());
      exp_desc.push_back(d);
    end
  endtask

  // Compare process: every write and every descriptor pop against the model.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("we_eq_ce", 32'(sram_we_o[k]), 32'(sram_ce_o[k]));
        if (sram_ce_o[k]) begin
          cw_a.inst = k; cw_a.addr = sram_addr_o[k]; cw_a.sel = sram_sel_o[k]; cw_a.data = sram_data_o[k];
          act_wr.push_back(cw_a);
          if (exp_wr.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: inst %0d got addr %h, expected no write", k, sram_addr_o[k]);
          end else begin
            cw_e = exp_wr.pop_front();
            chk("wr_inst", 32'(k), 32'(cw_e.inst));
            chk("wr_addr", sram_addr_o[k], cw_e.addr);
            chk("wr_sel", 32'(sram_sel_o[k]), 32'(cw_e.sel));
            chk("wr_data", sram_data_o[k], cw_e.data);
          end
        end
        if (desc_valid[k] && desc_ready[k]) begin
          cd_a.inst = k; cd_a.addr = desc_addr[k]; cd_a.len = desc_len[k];
          act_desc.push_back(cd_a);
          if (exp_desc.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_desc: inst %0d got addr %h len %0d, expected none", k, desc_addr[k], desc_len[k]);
          end else begin
            cd_e = exp_desc.pop_front();
            chk("desc_inst", 32'(k), 32'(cd_e.inst));
            chk("desc_addr", desc_addr[k], cd_e.addr);
            chk("desc_len", 32'(desc_len[k]), 32'(cd_e.len));
          end
        end
      end
    end
  end

  task automatic fill(input int first, input int n);
    pkt_q.delete();
    for (int i = 0; i < n; i++) pkt_q.push_back(8'(first + i));
  endtask

  task automatic send_byte(input int k, input logic [7:0] d, input logic s, input logic e,
                           output int stall);
    stall = 0;
    in_valid[k] = 1'b1; in_data[k] = d; in_sop[k] = s; in_eop[k] = e;
    @(negedge clk);
    while (!in_ready[k] && stall < 200) begin
      stall++;
      @(negedge clk);
    end
    if (!in_ready[k]) begin
      total++; bad++;
      $display("FAIL handshake_timeout: inst %0d in_ready got 0 for %0d cycles, expected 1", k, stall);
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0; in_sop[k] = 1'b0; in_eop[k] = 1'b0;
  endtask

  task automatic send_pkt(input int k, input bit aborted, output int stall0);
    int st;
    stall0 = 0;
    model_pkt(k, aborted);
    for (int i = 0; i < pkt_q.size(); i++) begin
      send_byte(k, pkt_q[i], i == 0, !aborted && (i == pkt_q.size() - 1), st);
      if (i == 0) stall0 = st;
    end
  endtask

  task automatic release_words(input int k, input int w);
    m_occ[k] = (w > m_occ[k]) ? 0 : m_occ[k] - w;
    rel_valid[k] = 1'b1; rel_words[k] = 13'(w);
    @(posedge clk); #1;
    rel_valid[k] = 1'b0; rel_words[k] = '0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_wr.size() != 0 || exp_desc.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_writes_left", 32'(exp_wr.size()), 32'd0);
    chk("drain_descs_left", 32'(exp_desc.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_wr[k] = 0; m_occ[k] = 0; m_drop[k] = 0;
    end
    exp_wr.delete(); exp_desc.delete();
    act_wr.delete(); act_desc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; in_sop[k] = 1'b0; in_eop[k] = 1'b0;
      desc_ready[k] = 1'b1; rel_valid[k] = 1'b0; rel_words[k] = '0;
    end
    m_n[0] = 256;
    m_n[1] = 4;

    // Reset state
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_ce", 32'(sram_ce_o[k]), 32'd0);
      chk("rst_we", 32'(sram_we_o[k]), 32'd0);
      chk("rst_addr", sram_addr_o[k], 32'd0);
      chk("rst_sel", 32'(sram_sel_o[k]), 32'd0);
      chk("rst_data", sram_data_o[k], 32'd0);
      chk("rst_desc_valid", 32'(desc_valid[k]), 32'd0);
      chk("rst_desc_addr", desc_addr[k], 32'd0);
      chk("rst_desc_len", 32'(desc_len[k]), 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt[k]), 32'd0);
      chk("rst_in_ready", 32'(in_ready[k]), 32'd1);
    end
    repeat (5) @(posedge clk);
    #1;

    // 6-byte packet 01..06, default ring
    fill(8'h01, 6);
    model_pkt(0, 0);
    for (int i = 0; i < 6; i++) begin
      send_byte(0, pkt_q[i], i == 0, i == 5, st);
      if (i == 3) chk("lat_word_ce", 32'(sram_ce_o[0]), 32'd1);
      if (i == 5) begin
        chk("lat_last_ce", 32'(sram_ce_o[0]), 32'd1);
        chk("commit_in_ready", 32'(in_ready[0]), 32'd0);
        chk("commit_desc_valid", 32'(desc_valid[0]), 32'd0);
        @(posedge clk); #1;
        chk("desc_valid_t2", 32'(desc_valid[0]), 32'd1);
        chk("desc_head_addr", desc_addr[0], 32'h0000_1000);
        chk("desc_head_len", 32'(desc_len[0]), 32'd6);
      end
    end
    drain();
    chk("p6_nwr", 32'(act_wr.size()), 32'd2);
    chk("p6_w0_addr", act_wr[0].addr, 32'h0000_1000);
    chk("p6_w0_data", act_wr[0].data, 32'h0403_0201);
    chk("p6_w0_sel", 32'(act_wr[0].sel), 32'hF);
    chk("p6_w1_addr", act_wr[1].addr, 32'h0000_1004);
    chk("p6_w1_data", act_wr[1].data, 32'h0000_0605);
    chk("p6_w1_sel", 32'(act_wr[1].sel), 32'h3);
    chk("p6_ndesc", 32'(act_desc.size()), 32'd1);
    chk("p6_desc_addr", act_desc[0].addr, 32'h0000_1000);
    chk("p6_desc_len", 32'(act_desc[0].len), 32'd6);
    chk("p6_drop", 32'(drop_cnt[0]), 32'd0);

    // Ring wrap on the 4-word instance
    do_reset();
    fill(8'hA0, 8);
    send_pkt(1, 0, st);
    release_words(1, 2);
    fill(8'h11, 12);
    send_pkt(1, 0, st);
    drain();
    chk("wrap_nwr", 32'(act_wr.size()), 32'd5);
    chk("wrap_w2_addr", act_wr[2].addr, 32'h0000_1008);
    chk("wrap_w2_data", act_wr[2].data, 32'h1413_1211);
    chk("wrap_w3_addr", act_wr[3].addr, 32'h0000_100C);
    chk("wrap_w4_addr", act_wr[4].addr, 32'h0000_1000);
    chk("wrap_w4_data", act_wr[4].data, 32'h1C1B_1A19);
    chk("wrap_desc_addr", act_desc[1].addr, 32'h0000_1008);
    chk("wrap_desc_len", 32'(act_desc[1].len), 32'd12);
    chk("wrap_drop", 32'(drop_cnt[1]), 32'd0);

    // Overflow on the 4-word instance, no release
    do_reset();
    fill(8'h30, 20);
    send_pkt(1, 0, st);
    fill(8'h55, 1);
    send_pkt(1, 0, st);
    drain();
    chk("ovf_nwr", 32'(act_wr.size()), 32'd5);
    chk("ovf_w3_addr", act_wr[3].addr, 32'h0000_100C);
    chk("ovf_w4_addr", act_wr[4].addr, 32'h0000_1000);
    chk("ovf_w4_sel", 32'(act_wr[4].sel), 32'h1);
    chk("ovf_w4_data", act_wr[4].data, 32'h0000_0055);
    chk("ovf_ndesc", 32'(act_desc.size()), 32'd1);
    chk("ovf_desc_len", 32'(act_desc[0].len), 32'd1);
    chk("ovf_drop", 32'(drop_cnt[1]), 32'd1);

    // Descriptor back-pressure
    do_reset();
    desc_ready[0] = 1'b0;
    for (int p = 0; p < 5; p++) begin
      fill(8'h61 + p, 1);
      send_pkt(0, 0, st);
    end
    for (int c = 0; c < 3; c++) begin
      repeat (2) @(posedge clk);
      #1;
      chk("bp_in_ready_stuck", 32'(in_ready[0]), 32'd0);
      chk("bp_desc_valid", 32'(desc_valid[0]), 32'd1);
    end
    chk("bp_head_addr", desc_addr[0], 32'h0000_1000);
    chk("bp_head_len", 32'(desc_len[0]), 32'd1);
    desc_ready[0] = 1'b1;
    drain();
    chk("bp_ndesc", 32'(act_desc.size()), 32'd5);
    chk("bp_d0_addr", act_desc[0].addr, 32'h0000_1000);
    chk("bp_d4_addr", act_desc[4].addr, 32'h0000_1010);
    chk("bp_d4_len", 32'(act_desc[4].len), 32'd1);
    chk("bp_in_ready_back", 32'(in_ready[0]), 32'd1);

    // sop after 3 bytes aborts the packet
    do_reset();
    fill(8'h71, 3);
    send_pkt(0, 1, st);
    fill(8'h81, 3);
    send_pkt(0, 0, st);
    chk("abort_stall_cycles", 32'(st), 32'd1);
    drain();
    chk("abort_drop", 32'(drop_cnt[0]), 32'd1);
    chk("abort_nwr", 32'(act_wr.size()), 32'd1);
    chk("abort_w_addr", act_wr[0].addr, 32'h0000_1000);
    chk("abort_w_sel", 32'(act_wr[0].sel), 32'h7);
    chk("abort_w_data", act_wr[0].data, 32'h0083_8281);
    chk("abort_ndesc", 32'(act_desc.size()), 32'd1);
    chk("abort_desc_len", 32'(act_desc[0].len), 32'd3);

    // Reset mid-packet discards it; next packet starts at ring word 0
    send_byte(0, 8'hE0, 1'b1, 1'b0, st);
    send_byte(0, 8'hE1, 1'b0, 1'b0, st);
    do_reset();
    chk("mid_rst_desc_valid", 32'(desc_valid[0]), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt[0]), 32'd0);
    fill(8'h99, 1);
    send_pkt(0, 0, st);
    drain();
    chk("mid_rst_addr", act_wr[0].addr, 32'h0000_1000);
    chk("mid_rst_desc_addr", act_desc[0].addr, 32'h0000_1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
